c2_window_buf: RTL and testbench

Second-conv input stage.
- Accepts the pool-1 feature map (12×12 pixels, 6 channels × 16 bit per pixel) as a raster-order serial stream from the pool-1 data FIFO.
- Builds every 5×5 sliding window with line buffers and presents each window in parallel to the conv-2 MAC array.
- Drives the `c2_ready` read-enable qualifier back to the FIFO and tolerates its one-cycle valid-after-ready latency.

---
 rtl/cnn_pkg.sv | 12 +
 rtl/c2_line_ram.sv | 49 ++++
 rtl/c2_window_buf.sv | 141 ++++++++++++++
 tb/tb_c2_window_buf.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN datapath blocks.
package cnn_pkg;

  localparam int unsigned C2_IMG_W = 12;
  localparam int unsigned C2_IMG_H = 12;
  localparam int unsigned C2_K     = 5;
  localparam int unsigned C2_CH    = 6;
  localparam int unsigned DW       = 16;

  typedef logic [C2_CH*DW-1:0] pix_t;

endpackage

// File: rtl/c2_line_ram.sv
// Circular line buffer of ROWS rows; one column read and written per consumed pixel.
module c2_line_ram
  import cnn_pkg::*;
#(
  parameter int unsigned IMG_W = C2_IMG_W,
  parameter int unsigned ROWS  = C2_K - 1,
  parameter int unsigned PW    = $bits(pix_t),
  localparam int unsigned CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int unsigned PTRW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic               eol,
  input  logic [CW-1:0]      col,
  input  logic [PW-1:0]      wdata,
  output logic [ROWS*PW-1:0] rdata
);

  logic [PW-1:0]   mem [ROWS][IMG_W];
  logic [PTRW-1:0] ptr_q, ptr_d;

  // ptr_q addresses the oldest row; it is read as the top row and then overwritten.
  always_comb begin
    int unsigned slot;
    slot  = 0;
    rdata = '0;
    for (int i = 0; i < ROWS; i++) begin
      slot = 32'(ptr_q) + 32'(i);
      if (slot >= ROWS) slot = slot - ROWS;
      rdata[i*PW +: PW] = mem[slot[PTRW-1:0]][col];
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (we && eol) ptr_d = (ptr_q == PTRW'(ROWS - 1)) ? '0 : ptr_q + PTRW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  always_ff @(posedge clk) begin
    if (we) mem[ptr_q][col] <= wdata;
  end

endmodule

// File: rtl/c2_window_buf.sv
// Conv-2 input stage: builds KxK sliding windows from a raster pixel stream with a
// one-entry skid register absorbing the pixel in flight when the window stage stalls.
module c2_window_buf #(
  parameter int unsigned IMG_W = cnn_pkg::C2_IMG_W,
  parameter int unsigned IMG_H = cnn_pkg::C2_IMG_H,
  parameter int unsigned K     = cnn_pkg::C2_K,
  parameter int unsigned CH    = cnn_pkg::C2_CH,
  parameter int unsigned DW    = cnn_pkg::DW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH*DW-1:0]      data_in,
  input  logic                  data_in_valid,
  output logic                  c2_ready,
  output logic [K*K*CH*DW-1:0]  win_out,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic                  frame_done,
  output logic                  overflow
);

  localparam int unsigned PW = CH * DW;
  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [PW-1:0]        skid_q, skid_d;
  logic                 skid_full_q, skid_full_d;
  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;
  logic [PW-1:0]        win_q [K][K];
  logic [PW-1:0]        win_d [K][K];
  logic                 win_valid_q, win_valid_d;
  logic                 frame_done_q, frame_done_d;
  logic                 overflow_q, overflow_d;
  logic                 advance, consume_skid, consume_in, consume;
  logic                 eol, last;
  logic [PW-1:0]        pix;
  logic [(K-1)*PW-1:0]  lb_col;

  assign advance      = !win_valid_q || win_ready;
  assign consume_skid = skid_full_q && advance;
  assign consume_in   = !skid_full_q && advance && data_in_valid;
  assign consume      = consume_skid || consume_in;
  assign pix          = skid_full_q ? skid_q : data_in;
  assign eol          = (col_q == CW'(IMG_W - 1));
  assign last         = eol && (row_q == RW'(IMG_H - 1));
  assign c2_ready     = !rst && !skid_full_q && advance;

  c2_line_ram #(
    .IMG_W (IMG_W),
    .ROWS  (K - 1),
    .PW    (PW)
  ) u_line_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (consume),
    .eol   (eol),
    .col   (col_q),
    .wdata (pix),
    .rdata (lb_col)
  );

  // A pixel not taken directly parks in skid; a second one with skid occupied is lost.
  always_comb begin
    skid_d      = skid_q;
    skid_full_d = skid_full_q;
    overflow_d  = overflow_q;
    if (consume_skid) skid_full_d = 1'b0;
    if (data_in_valid && !consume_in) begin
      if (skid_full_q && !consume_skid) begin
        overflow_d = 1'b1;
      end else begin
        skid_d      = data_in;
        skid_full_d = 1'b1;
      end
    end
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (consume) begin
      if (eol) begin
        col_d = '0;
        row_d = last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_comb begin
    win_d        = win_q;
    win_valid_d  = win_valid_q && !win_ready;
    frame_done_d = consume && last;
    if (consume) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++) win_d[i][j] = win_q[i][j+1];
      end
      for (int i = 0; i < K - 1; i++) win_d[i][K-1] = lb_col[i*PW +: PW];
      win_d[K-1][K-1] = pix;
      win_valid_d     = (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_q       <= '0;
      skid_full_q  <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) win_q[i][j] <= '0;
      end
    end else begin
      skid_q       <= skid_d;
      skid_full_q  <= skid_full_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      win_q        <= win_d;
    end
  end

  always_comb begin
    win_out = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) win_out[(i*K+j)*PW +: PW] = win_q[i][j];
    end
  end

  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_c2_window_buf.sv
// Directed bench for c2_window_buf: streams, backpressure, overflow, resets, frame chaining.
module tb_c2_window_buf;

  localparam int IMG_W = 12;
  localparam int IMG_H = 12;
  localparam int K     = 5;
  localparam int CH    = 6;
  localparam int DW    = 16;
  localparam int PW    = CH * DW;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int NWX   = IMG_W - K + 1;
  localparam int NWIN  = NWX * (IMG_H - K + 1);

  logic                 clk = 1'b0;
  logic                 rst;
  logic [PW-1:0]        data_in;
  logic                 data_in_valid;
  logic                 c2_ready;
  logic [K*K*PW-1:0]    win_out;
  logic                 win_valid;
  logic                 win_ready;
  logic                 frame_done;
  logic                 overflow;

  c2_window_buf #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .K     (K),
    .CH    (CH),
    .DW    (DW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .c2_ready      (c2_ready),
    .win_out       (win_out),
    .win_valid     (win_valid),
    .win_ready     (win_ready),
    .frame_done    (frame_done),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int cyc, src_idx, src_n, wins, fd_cnt, t53, t144, stall_at, stall_left;
  bit req, force_v, hold_wr, check_lat, first_seen, in_stall;

  task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] pix(input int r, input int c, input int base);
    logic [PW-1:0] p;
    p = '0;
    for (int k = 0; k < CH; k++) p[k*DW +: DW] = DW'(base + r*16 + c + k*256);
    return p;
  endfunction

  function automatic logic [PW-1:0] src_pix(input int p);
    int f, q;
    f = p / NPIX;
    q = p % NPIX;
    return pix(q / IMG_W, q % IMG_W, f * 32768);
  endfunction

  // Window w (counting across frames) has its top-left pixel at (q/NWX, q%NWX).
  task automatic check_window(input int w);
    int f, q, r0, c0;
    f  = w / NWIN;
    q  = w % NWIN;
    r0 = q / NWX;
    c0 = q % NWX;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        chk($sformatf("w%0d_e%0d%0d", w, i, j), win_out[(i*K+j)*PW +: PW],
            pix(r0 + i, c0 + j, f * 32768));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (req) begin
      data_in       = src_pix(src_idx);
      data_in_valid = 1'b1;
      if (src_idx == 52) t53 = cyc;
      if (src_idx % NPIX == NPIX - 1) t144 = cyc;
      src_idx++;
    end else if (force_v) begin
      data_in       = '1;
      data_in_valid = 1'b1;
    end else begin
      data_in       = '0;
      data_in_valid = 1'b0;
    end
    if (hold_wr) begin
      win_ready = 1'b0;
    end else if (stall_left > 0 && wins == stall_at) begin
      win_ready = 1'b0;
      stall_left--;
    end else begin
      win_ready = 1'b1;
    end
    @(negedge clk);
    if (win_valid) begin
      if (wins == 0 && !first_seen) begin
        first_seen = 1'b1;
        if (check_lat) begin
          chk("first_win_lat", PW'(cyc), PW'(t53 + 1));
          chk("e00_ch0", PW'(win_out[DW-1:0]), PW'(16'h000));
          chk("e44_ch0", PW'(win_out[24*PW +: DW]), PW'(16'h044));
        end
      end
      check_window(wins);
      if (win_ready) begin
        wins++;
        in_stall = 1'b0;
      end else if (!in_stall) begin
        in_stall = 1'b1;
        chk("ready_drop", PW'(c2_ready), PW'(0));
      end
    end
    if (frame_done) begin
      fd_cnt++;
      if (check_lat) chk("frame_done_lat", PW'(cyc), PW'(t144 + 1));
    end
    req = c2_ready && (src_idx < src_n);
  endtask

  task automatic reset_dut(input bit do_chk, input int n);
    @(posedge clk);
    #1;
    rst           = 1'b1;
    data_in       = '0;
    data_in_valid = 1'b0;
    win_ready     = 1'b0;
    force_v       = 1'b0;
    hold_wr       = 1'b0;
    req           = 1'b0;
    @(negedge clk);
    if (do_chk) begin
      chk("rst_c2_ready", PW'(c2_ready), PW'(0));
      chk("rst_win_valid", PW'(win_valid), PW'(0));
      chk("rst_frame_done", PW'(frame_done), PW'(0));
      chk("rst_overflow", PW'(overflow), PW'(0));
      for (int e = 0; e < K*K; e++) chk($sformatf("rst_win_e%0d", e), win_out[e*PW +: PW], '0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rel_c2_ready", PW'(c2_ready), PW'(1));
    cyc        = 0;
    src_idx    = 0;
    src_n      = n;
    wins       = 0;
    fd_cnt     = 0;
    t53        = -100;
    t144       = -100;
    first_seen = 1'b0;
    in_stall   = 1'b0;
    stall_at   = -1;
    stall_left = 0;
    req        = c2_ready && (src_n > 0);
  endtask

  task automatic run_wins(input int target, input int budget);
    int n;
    n = 0;
    while (wins < target && n < budget) begin
      step();
      n++;
    end
    if (wins < target) chk("timeout_wins", PW'(wins), PW'(target));
  endtask

  task automatic run_pix(input int target, input int budget);
    int n;
    n = 0;
    while (src_idx < target && n < budget) begin
      step();
      n++;
    end
    if (src_idx < target) chk("timeout_pix", PW'(src_idx), PW'(target));
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  initial begin
    int n;
    rst           = 1'b1;
    data_in       = '0;
    data_in_valid = 1'b0;
    win_ready     = 1'b0;
    force_v       = 1'b0;
    hold_wr       = 1'b0;
    req           = 1'b0;
    check_lat     = 1'b0;

    // Continuous stream.
    reset_dut(1'b1, NPIX);
    check_lat = 1'b1;
    run_wins(NWIN, 400);
    idle(20);
    chk("t1_wins", PW'(wins), PW'(NWIN));
    chk("t1_frame_done", PW'(fd_cnt), PW'(1));
    chk("t1_overflow", PW'(overflow), PW'(0));

    // Backpressure on the third window.
    reset_dut(1'b0, NPIX);
    check_lat  = 1'b0;
    stall_at   = 2;
    stall_left = 10;
    run_wins(NWIN, 500);
    idle(20);
    chk("t2_wins", PW'(wins), PW'(NWIN));
    chk("t2_frame_done", PW'(fd_cnt), PW'(1));
    chk("t2_overflow", PW'(overflow), PW'(0));

    // Overflow: window stalled, skid holds the in-flight pixel, two more are pushed.
    reset_dut(1'b0, NPIX);
    hold_wr = 1'b1;
    n = 0;
    while (!win_valid && n < 300) begin
      step();
      n++;
    end
    chk("t3_win_up", PW'(win_valid), PW'(1));
    src_n = src_idx;
    idle(3);
    chk("t3_ovf_pre", PW'(overflow), PW'(0));
    force_v = 1'b1;
    idle(2);
    force_v = 1'b0;
    idle(1);
    chk("t3_ovf_set", PW'(overflow), PW'(1));
    idle(5);
    chk("t3_ovf_sticky", PW'(overflow), PW'(1));

    // Mid-frame reset at beat 70, then a fresh frame.
    reset_dut(1'b1, NPIX);
    run_pix(70, 200);
    reset_dut(1'b1, NPIX);
    check_lat = 1'b1;
    run_wins(NWIN, 400);
    idle(20);
    chk("t4_wins", PW'(wins), PW'(NWIN));
    chk("t4_frame_done", PW'(fd_cnt), PW'(1));

    // Two frames back to back with distinct pixel values.
    reset_dut(1'b0, 2 * NPIX);
    check_lat = 1'b1;
    run_wins(2 * NWIN, 700);
    idle(20);
    chk("t5_wins", PW'(wins), PW'(2 * NWIN));
    chk("t5_frame_done", PW'(fd_cnt), PW'(2));
    chk("t5_overflow", PW'(overflow), PW'(0));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
